// File: rtl/qos_pkg.sv
// Shared definitions for the two-VC QoS scheduler: FSM encodings,
// the destination-select bit of a head word, and default widths.
package qos_pkg;

    localparam logic [1:0] ST_RESET  = 2'd0;
    localparam logic [1:0] ST_INIT   = 2'd1;
    localparam logic [1:0] ST_IDLE   = 2'd2;
    localparam logic [1:0] ST_ACTIVE = 2'd3;

    localparam int DEST_BIT  = 4;
    localparam int DEF_BW    = 6;
    localparam int DEF_LEN4  = 4;
    localparam int DEF_LEN16 = 16;
    localparam int DEF_WW    = 3;
    localparam int DEF_CW    = 8;

    typedef enum logic {
        VC0 = 1'b0,
        VC1 = 1'b1
    } vc_e;

endpackage

// File: rtl/vc_qos_scheduler_if.sv
// FIFO-side bundle of the scheduler: VC FIFO status/head words, destination
// backpressure and the pop strobes returned to the VC FIFOs.
interface vc_qos_scheduler_if #(
    parameter int BW = qos_pkg::DEF_BW
);
    logic          VC0_empty;
    logic          VC1_empty;
    logic [BW-1:0] VC0_head;
    logic [BW-1:0] VC1_head;
    logic          D0_almost_full;
    logic          D1_almost_full;
    logic          VC0_rd;
    logic          VC1_rd;

    modport master (
        input  VC0_empty, VC1_empty, VC0_head, VC1_head,
        input  D0_almost_full, D1_almost_full,
        output VC0_rd, VC1_rd
    );

    modport slave (
        output VC0_empty, VC1_empty, VC0_head, VC1_head,
        output D0_almost_full, D1_almost_full,
        input  VC0_rd, VC1_rd
    );
endinterface

// File: rtl/wrr_arb2.sv
// Two-requester weighted round-robin: the owner keeps the grant for up to its
// weight in consecutive pops, then yields; an idle competitor never blocks it.
module wrr_arb2
    import qos_pkg::*;
#(
    parameter int WW = DEF_WW
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          clear,
    input  logic          enable,
    input  logic [WW-1:0] weight0,
    input  logic [WW-1:0] weight1,
    input  logic [1:0]    elig,
    output logic [1:0]    grant
);

    vc_e           owner;
    logic [WW-1:0] run;
    logic [WW-1:0] w0_eff;
    logic [WW-1:0] w1_eff;
    logic [WW-1:0] w_own;
    logic          elig_own;
    logic          elig_oth;
    logic          take_own;
    logic          take_oth;

    assign w0_eff   = (weight0 == '0) ? WW'(1) : weight0;
    assign w1_eff   = (weight1 == '0) ? WW'(1) : weight1;
    assign w_own    = (owner == VC1) ? w1_eff : w0_eff;
    assign elig_own = (owner == VC1) ? elig[1] : elig[0];
    assign elig_oth = (owner == VC1) ? elig[0] : elig[1];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        take_own = 1'b0;
        take_oth = 1'b0;
        if (enable) begin
            if (elig_own && (run < w_own)) take_own = 1'b1;
            else if (elig_oth)             take_oth = 1'b1;
            else if (elig_own)             take_own = 1'b1;
        end
    end

    always_comb begin
        grant = 2'b00;
        if (take_own) grant[owner]  = 1'b1;
        if (take_oth) grant[~owner] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on the edge.
    always_ff @(posedge clk) begin
        if (!reset_L || clear) begin
            owner <= VC0;
            run   <= '0;
        end else if (take_oth) begin
            owner <= vc_e'(~owner);
            run   <= WW'(1);
        end else if (take_own) begin
            run   <= (run < w_own) ? run + WW'(1) : WW'(1);
        end
    end

endmodule

// File: rtl/vc_qos_scheduler.sv
// Central QoS controller: bring-up FSM, threshold latching during INIT, and
// weighted round-robin VC pops gated by destination backpressure.
module vc_qos_scheduler
    import qos_pkg::*;
#(
    parameter int BW       = DEF_BW,
    parameter int LEN4     = DEF_LEN4,
    parameter int LEN16    = DEF_LEN16,
    parameter int WW       = DEF_WW,
    parameter int DEST_BIT = qos_pkg::DEST_BIT,
    parameter int CW       = DEF_CW
) (
    input  logic               clk,
    input  logic               reset_L,
    input  logic               init,
    input  logic [WW-1:0]      cfg_weight0,
    input  logic [WW-1:0]      cfg_weight1,
    input  logic [LEN16-1:0]   cfg_umbralV_high,
    input  logic [LEN16-1:0]   cfg_umbralV_low,
    input  logic [LEN4-1:0]    cfg_umbralD_high,
    input  logic [LEN4-1:0]    cfg_umbralD_low,
    vc_qos_scheduler_if.master fifo,
    output logic               sel_vc1,
    output logic [LEN16-1:0]   UmbralV_HIGH,
    output logic [LEN16-1:0]   UmbralV_LOW,
    output logic [LEN4-1:0]    UmbralD_HIGH,
    output logic [LEN4-1:0]    UmbralD_LOW,
    output logic [1:0]         state,
    output logic [CW-1:0]      grant_cnt0,
    output logic [CW-1:0]      grant_cnt1,
    output logic               idle
);

    localparam int DEST_IDX = (DEST_BIT < BW) ? DEST_BIT : BW - 1;

    logic [1:0]    state_n;
    logic [WW-1:0] weight0_q;
    logic [WW-1:0] weight1_q;
    logic [1:0]    elig;
    logic [1:0]    grant;
    logic          arb_enable;
    logic          arb_clear;
    logic          in_setup;

    assign in_setup = (state == ST_RESET) || (state == ST_INIT);
    assign idle     = (state == ST_IDLE);

    // A head word whose destination is about to fill is not eligible, so it never stalls the other VC.
    assign elig[0] = !fifo.VC0_empty &&
                     !(fifo.VC0_head[DEST_IDX] ? fifo.D1_almost_full : fifo.D0_almost_full);
    assign elig[1] = !fifo.VC1_empty &&
                     !(fifo.VC1_head[DEST_IDX] ? fifo.D1_almost_full : fifo.D0_almost_full);

    // reset_L in the enable drops the strobes in the very cycle reset is sampled.
    assign arb_enable = reset_L && (state == ST_ACTIVE) && !init;
    assign arb_clear  = in_setup;

    wrr_arb2 #(.WW(WW)) u_arb (
        .clk     (clk),
        .reset_L (reset_L),
        .clear   (arb_clear),
        .enable  (arb_enable),
        .weight0 (weight0_q),
        .weight1 (weight1_q),
        .elig    (elig),
        .grant   (grant)
    );

    assign fifo.VC0_rd = grant[0];
    assign fifo.VC1_rd = grant[1];

    always_comb begin
        state_n = state;
        case (state)
            ST_RESET:  state_n = ST_INIT;
            ST_INIT:   if (!init) state_n = ST_IDLE;
            ST_IDLE: begin
                if (init)                                    state_n = ST_INIT;
                else if (!fifo.VC0_empty || !fifo.VC1_empty) state_n = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (init)                                   state_n = ST_INIT;
                else if (fifo.VC0_empty && fifo.VC1_empty)  state_n = ST_IDLE;
            end
            default:   state_n = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state        <= ST_RESET;
            sel_vc1      <= 1'b0;
            UmbralV_HIGH <= '0;
            UmbralV_LOW  <= '0;
            UmbralD_HIGH <= '0;
            UmbralD_LOW  <= '0;
            weight0_q    <= '0;
            weight1_q    <= '0;
            grant_cnt0   <= '0;
            grant_cnt1   <= '0;
        end else begin
            state <= state_n;
            if (state == ST_INIT) begin
                UmbralV_HIGH <= cfg_umbralV_high;
                UmbralV_LOW  <= cfg_umbralV_low;
                UmbralD_HIGH <= cfg_umbralD_high;
                UmbralD_LOW  <= cfg_umbralD_low;
                weight0_q    <= cfg_weight0;
                weight1_q    <= cfg_weight1;
            end
            // sel_vc1 lines up with the read data of the pop it follows; it holds when nothing pops.
            if (grant != 2'b00) sel_vc1 <= grant[1];
            if (in_setup) begin
                grant_cnt0 <= '0;
                grant_cnt1 <= '0;
            end else begin
                if (grant[0] && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + CW'(1);
                if (grant[1] && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_vc_qos_scheduler.sv
// Bench for vc_qos_scheduler: table-driven bring-up, directed corner sequences,
// and random traffic checked against a behavioural model of the scheduling rules.
module tb_vc_qos_scheduler;

    logic        clk = 1'b0;
    logic        reset_L;
    logic        init;
    logic [2:0]  cfg_weight0, cfg_weight1;
    logic [15:0] cfg_umbralV_high, cfg_umbralV_low;
    logic [3:0]  cfg_umbralD_high, cfg_umbralD_low;

    logic        sel_vc1, sel_vc1_b;
    logic [15:0] vh, vl, vh_b, vl_b;
    logic [3:0]  dh, dl, dh_b, dl_b;
    logic [1:0]  state, state_b;
    logic [7:0]  cnt0, cnt1;
    logic [2:0]  cnt0_b, cnt1_b;
    logic        idle, idle_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    vc_qos_scheduler_if #(.BW(6)) bus ();
    vc_qos_scheduler_if #(.BW(6)) bus_b ();

    assign bus_b.VC0_empty      = bus.VC0_empty;
    assign bus_b.VC1_empty      = bus.VC1_empty;
    assign bus_b.VC0_head       = bus.VC0_head;
    assign bus_b.VC1_head       = bus.VC1_head;
    assign bus_b.D0_almost_full = bus.D0_almost_full;
    assign bus_b.D1_almost_full = bus.D1_almost_full;

    vc_qos_scheduler #(.CW(8)) dut (
        .clk(clk), .reset_L(reset_L), .init(init),
        .cfg_weight0(cfg_weight0), .cfg_weight1(cfg_weight1),
        .cfg_umbralV_high(cfg_umbralV_high), .cfg_umbralV_low(cfg_umbralV_low),
        .cfg_umbralD_high(cfg_umbralD_high), .cfg_umbralD_low(cfg_umbralD_low),
        .fifo(bus.master), .sel_vc1(sel_vc1),
        .UmbralV_HIGH(vh), .UmbralV_LOW(vl), .UmbralD_HIGH(dh), .UmbralD_LOW(dl),
        .state(state), .grant_cnt0(cnt0), .grant_cnt1(cnt1), .idle(idle)
    );

    vc_qos_scheduler #(.CW(3)) dut_sat (
        .clk(clk), .reset_L(reset_L), .init(init),
        .cfg_weight0(cfg_weight0), .cfg_weight1(cfg_weight1),
        .cfg_umbralV_high(cfg_umbralV_high), .cfg_umbralV_low(cfg_umbralV_low),
        .cfg_umbralD_high(cfg_umbralD_high), .cfg_umbralD_low(cfg_umbralD_low),
        .fifo(bus_b.master), .sel_vc1(sel_vc1_b),
        .UmbralV_HIGH(vh_b), .UmbralV_LOW(vl_b), .UmbralD_HIGH(dh_b), .UmbralD_LOW(dl_b),
        .state(state_b), .grant_cnt0(cnt0_b), .grant_cnt1(cnt1_b), .idle(idle_b)
    );

    // Reference model: pops since last clear are counted unbounded, saturation applied on compare.
    int m_state, m_owner, m_run, m_w0, m_w1, m_sel;
    int m_vh, m_vl, m_dh, m_dl;
    int raw0, raw1;
    bit eg0, eg1;
    bit s_rd0, s_rd1, s_sel;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    function automatic bit vc_ready(input bit empty, input bit dest, input bit af0, input bit af1);
        return !empty && !(dest ? af1 : af0);
    endfunction

    task automatic model_comb();
        bit e0, e1, e_own, e_oth;
        int w_own, winner;
        e0 = vc_ready(bus.VC0_empty, bus.VC0_head[4], bus.D0_almost_full, bus.D1_almost_full);
        e1 = vc_ready(bus.VC1_empty, bus.VC1_head[4], bus.D0_almost_full, bus.D1_almost_full);
        eg0 = 0;
        eg1 = 0;
        if (reset_L && m_state == 3 && !init) begin
            w_own  = (m_owner == 1) ? m_w1 : m_w0;
            e_own  = (m_owner == 1) ? e1 : e0;
            e_oth  = (m_owner == 1) ? e0 : e1;
            winner = -1;
            if (e_own && m_run < w_own) winner = m_owner;
            else if (e_oth)             winner = 1 - m_owner;
            else if (e_own)             winner = m_owner;
            eg0 = (winner == 0);
            eg1 = (winner == 1);
        end
    endtask

    task automatic model_seq();
        if (!reset_L) begin
            m_state = 0; m_owner = 0; m_run = 0; m_sel = 0;
            m_w0 = 1; m_w1 = 1; m_vh = 0; m_vl = 0; m_dh = 0; m_dl = 0;
            raw0 = 0; raw1 = 0;
            return;
        end
        case (m_state)
            0: begin
                m_state = 1; raw0 = 0; raw1 = 0; m_owner = 0; m_run = 0;
            end
            1: begin
                m_vh = cfg_umbralV_high; m_vl = cfg_umbralV_low;
                m_dh = cfg_umbralD_high; m_dl = cfg_umbralD_low;
                m_w0 = (cfg_weight0 == 0) ? 1 : int'(cfg_weight0);
                m_w1 = (cfg_weight1 == 0) ? 1 : int'(cfg_weight1);
                raw0 = 0; raw1 = 0; m_owner = 0; m_run = 0;
                m_state = init ? 1 : 2;
            end
            2: m_state = init ? 1 : ((!bus.VC0_empty || !bus.VC1_empty) ? 3 : 2);
            default: begin
                if (init) m_state = 1;
                else begin
                    if (eg0 || eg1) begin
                        int win;
                        win = eg1 ? 1 : 0;
                        if (win == m_owner)
                            m_run = (m_run < ((win == 1) ? m_w1 : m_w0)) ? m_run + 1 : 1;
                        else begin
                            m_owner = win; m_run = 1;
                        end
                        m_sel = win;
                        raw0 += int'(eg0);
                        raw1 += int'(eg1);
                    end
                    if (bus.VC0_empty && bus.VC1_empty) m_state = 2;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        model_comb();
        s_rd0 = bus.VC0_rd;
        s_rd1 = bus.VC1_rd;
        s_sel = sel_vc1;
        check("vc0_rd", int'(bus.VC0_rd), int'(eg0));
        check("vc1_rd", int'(bus.VC1_rd), int'(eg1));
        check("state", int'(state), m_state);
        check("sel_vc1", int'(sel_vc1), m_sel);
        check("umbralV_high", int'(vh), m_vh);
        check("umbralV_low", int'(vl), m_vl);
        check("umbralD_high", int'(dh), m_dh);
        check("umbralD_low", int'(dl), m_dl);
        check("grant_cnt0", int'(cnt0), sat(raw0, 255));
        check("grant_cnt1", int'(cnt1), sat(raw1, 255));
        check("idle", int'(idle), int'(m_state == 2));
        check("cw3_grant_cnt0", int'(cnt0_b), sat(raw0, 7));
        check("cw3_grant_cnt1", int'(cnt1_b), sat(raw1, 7));
        check("cw3_vc0_rd", int'(bus_b.VC0_rd), int'(eg0));
    endtask

    // Inputs are set by the caller just after a rising edge; outputs are compared on the falling edge.
    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_seq();
        #1;
    endtask

    task automatic do_init(input logic [2:0] w0, input logic [2:0] w1);
        cfg_weight0 = w0;
        cfg_weight1 = w1;
        init = 1'b1;
        step();
        init = 1'b0;
        step();
    endtask

    typedef struct {
        logic        rst_l;
        logic        init;
        logic [15:0] vhigh;
        logic [3:0]  dhigh;
        logic [1:0]  exp_state;
        logic [15:0] exp_vh;
        logic [3:0]  exp_dh;
    } vec_t;

    vec_t vecs[6];
    logic [7:0] pat;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 16'd0,  4'd0, 2'd0, 16'd0,  4'd0};
        vecs[1] = '{1'b1, 1'b1, 16'd12, 4'd3, 2'd1, 16'd0,  4'd0};
        vecs[2] = '{1'b1, 1'b1, 16'd12, 4'd3, 2'd1, 16'd12, 4'd3};
        vecs[3] = '{1'b1, 1'b1, 16'd12, 4'd3, 2'd1, 16'd12, 4'd3};
        vecs[4] = '{1'b1, 1'b0, 16'd12, 4'd3, 2'd2, 16'd12, 4'd3};
        vecs[5] = '{1'b1, 1'b0, 16'd0,  4'd0, 2'd2, 16'd12, 4'd3};

        reset_L = 1'b0; init = 1'b0;
        cfg_weight0 = 3'd3; cfg_weight1 = 3'd1;
        cfg_umbralV_high = '0; cfg_umbralV_low = 16'd2;
        cfg_umbralD_high = '0; cfg_umbralD_low = 4'd1;
        bus.VC0_empty = 1'b1; bus.VC1_empty = 1'b1;
        bus.VC0_head = '0; bus.VC1_head = '0;
        bus.D0_almost_full = 1'b0; bus.D1_almost_full = 1'b0;
        @(posedge clk);
        model_seq();
        #1;

        // Bring-up and threshold latching.
        for (int i = 0; i < 6; i++) begin
            reset_L = vecs[i].rst_l;
            init = vecs[i].init;
            cfg_umbralV_high = vecs[i].vhigh;
            cfg_umbralD_high = vecs[i].dhigh;
            step();
            check($sformatf("vec%0d_state", i), int'(state), int'(vecs[i].exp_state));
            check($sformatf("vec%0d_vhigh", i), int'(vh), int'(vecs[i].exp_vh));
            check($sformatf("vec%0d_dhigh", i), int'(dh), int'(vecs[i].exp_dh));
        end

        // Weighted pattern with w0=3, w1=1: VC0 x3 then VC1.
        bus.VC0_empty = 1'b0; bus.VC1_empty = 1'b0;
        step();
        pat = 8'b1000_1000;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("wrr%0d_vc1_rd", i), int'(s_rd1), int'(pat[i]));
            check($sformatf("wrr%0d_vc0_rd", i), int'(s_rd0), int'(!pat[i]));
            if (i > 0) check($sformatf("wrr%0d_sel", i), int'(s_sel), int'(pat[i-1]));
        end

        // VC0 blocked by D1 backpressure; VC1 keeps flowing, VC0 resumes on release.
        bus.VC0_head = 6'b01_0000; bus.VC1_head = 6'b00_0000;
        bus.D1_almost_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_vc0_blocked", int'(s_rd0), 0);
            check("bp_vc1_flows", int'(s_rd1), 1);
        end
        bus.D1_almost_full = 1'b0;
        step();
        check("bp_vc0_resume", int'(s_rd0), 1);

        // Counter saturation on the CW=3 instance after 9 VC0 pops.
        bus.VC0_empty = 1'b1; bus.VC1_empty = 1'b1; bus.VC0_head = '0;
        step();
        do_init(3'd3, 3'd0);
        bus.VC0_empty = 1'b0;
        step();
        for (int i = 0; i < 9; i++) step();
        check("sat_cnt0_cw3", int'(cnt0_b), 7);
        check("sat_cnt0_cw8", int'(cnt0), 9);

        // w1=0 behaves as weight 1; VC1 alone pops every cycle, then drains to IDLE.
        bus.VC0_empty = 1'b1; bus.VC1_empty = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("w1zero_vc1_rd", int'(s_rd1), 1);
        end
        bus.VC1_empty = 1'b1;
        step();
        check("drain_state", int'(state), 2);
        check("drain_idle", int'(idle), 1);

        // init during ACTIVE, then reset mid-ACTIVE.
        bus.VC0_empty = 1'b0;
        step();
        step();
        init = 1'b1;
        step();
        check("init_act_no_rd", int'(s_rd0 | s_rd1), 0);
        check("init_act_state", int'(state), 1);
        step();
        check("init_cnt0_clr", int'(cnt0), 0);
        check("init_cnt1_clr", int'(cnt1), 0);
        init = 1'b0;
        step();
        step();
        step();
        reset_L = 1'b0;
        step();
        check("rst_act_no_rd", int'(s_rd0 | s_rd1), 0);
        check("rst_act_state", int'(state), 0);
        reset_L = 1'b1;
        step();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset_L = ($urandom_range(59) != 0);
            init = ($urandom_range(24) == 0);
            cfg_weight0 = 3'($urandom_range(7));
            cfg_weight1 = 3'($urandom_range(7));
            cfg_umbralV_high = 16'($urandom);
            cfg_umbralV_low = 16'($urandom);
            cfg_umbralD_high = 4'($urandom);
            cfg_umbralD_low = 4'($urandom);
            bus.VC0_empty = ($urandom_range(3) == 0);
            bus.VC1_empty = ($urandom_range(3) == 0);
            bus.VC0_head = 6'($urandom);
            bus.VC1_head = 6'($urandom);
            bus.D0_almost_full = ($urandom_range(3) == 0);
            bus.D1_almost_full = ($urandom_range(3) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
